// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - frame size, output FSM state type and cosine coefficient table for dct_1d_stream
// Contents: N (samples per frame), dct_state_t, dct_coef()/dct_table() building
// C[k][n] = round(2^cf * s_k * cos((2n+1)k*pi/16)) as 32-bit two's-complement entries.
package dct_pkg;

    localparam int N = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dct_state_t;

    // 0.5*cos(m*pi/16) in Q30; m = 4 also serves as 1/(2*sqrt(2)) for k = 0.
    function automatic longint half_cos_q30(input int m);
        longint r;
        case (m)
            0:       r = 64'sd536870912;
            1:       r = 64'sd526555088;
            2:       r = 64'sd496004047;
            3:       r = 64'sd446391850;
            4:       r = 64'sd379625062;
            5:       r = 64'sd298269498;
            6:       r = 64'sd205451602;
            7:       r = 64'sd104738319;
            default: r = 64'sd0;
        endcase
        return r;
    endfunction

    // Angle folded into [0, pi] in units of pi/16; past pi/2 the cosine is negated.
    // Magnitude is rounded half-up before the sign is applied (round away from zero).
    function automatic int dct_coef(input int k, input int n, input int cf);
        int     a;
        longint mag;
        longint q;
        a = ((2 * n + 1) * k) % 32;
        if (a > 16) a = 32 - a;
        if (k == 0)     mag = half_cos_q30(4);
        else if (a > 8) mag = half_cos_q30(16 - a);
        else            mag = half_cos_q30(a);
        q = ((mag <<< cf) + (64'sd1 <<< 29)) >>> 30;
        return (k != 0 && a > 8) ? -int'(q) : int'(q);
    endfunction

    // Flattened table, entry index = k*8 + n.
    function automatic logic [63:0][31:0] dct_table(input int cf);
        logic [63:0][31:0] t;
        for (int k = 0; k < N; k++) begin
            for (int n = 0; n < N; n++) begin
                t[k * N + n] = 32'(dct_coef(k, n, cf));
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/dct_1d_stream_dot8.sv
// rtl/dct_1d_stream_dot8.sv - module dct_dot8: combinational 8-term signed dot product with rounding shift
// Ports: x[N] signed samples, c[N] signed coefficients (CF+2 bits),
//        y = (sum x[n]*c[n] + 2^(CF-1)) >>> CF at full accumulator width.
module dct_dot8
    import dct_pkg::*;
#(
    parameter int BWi   = 8,
    parameter int CF    = 12,
    parameter int ACC_W = BWi + CF + 5
) (
    input  logic signed [BWi-1:0]   x [N],
    input  logic signed [CF+1:0]    c [N],
    output logic signed [ACC_W-1:0] y
);

    logic signed [ACC_W-1:0] acc;

    // Rounding constant seeds the accumulator so the final shift rounds half-up.
    always_comb begin
        acc = '0;
        acc[CF-1] = 1'b1;
        for (int n = 0; n < N; n++) begin
            acc = acc + ACC_W'(x[n]) * ACC_W'(c[n]);
        end
    end

    assign y = acc >>> CF;

endmodule

// File: rtl/dct_1d_stream.sv
// rtl/dct_1d_stream.sv - streaming 8-point 1-D DCT-II, double-buffered frames, registered coefficient output
// Ports: clk, rst (async, active high); in_data/in_valid/in_ready sample stream;
//        out_data/out_valid/out_ready/out_last coefficient stream (out_last with k = 7).
// Macro DCT_1D_STREAM_SAT_EN: saturate y[k] to BWo bits; otherwise wrap to the low BWo bits.
module dct_1d_stream
    import dct_pkg::*;
#(
    parameter int BWi = 8,
    parameter int BWo = 10,
    parameter int CF  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [BWi-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic signed [BWo-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int ACC_W = BWi + CF + 5;
    localparam logic [63:0][31:0] COEF_TAB = dct_table(CF);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (BWo - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(64'sd1 <<< (BWo - 1)));

    logic signed [BWi-1:0]   fbuf  [N];
    logic signed [BWi-1:0]   cbuf  [N];
    logic signed [BWi-1:0]   inc   [N];
    logic signed [BWi-1:0]   dot_x [N];
    logic signed [CF+1:0]    coef  [N];
    logic signed [ACC_W-1:0] y;
    logic signed [BWo-1:0]   y_out;
    logic [3:0]              fcnt;
    logic [2:0]              k;
    logic [2:0]              row;
    dct_state_t              state;
    logic                    fill_full;
    logic                    cbuf_release;
    logic                    in_fire;
    logic                    frame_ready;
    logic                    load;

    // The compute buffer frees on the k=7 handshake, so a full fill buffer can
    // hand over and accept a new x[0] on that same edge.
    assign fill_full    = (fcnt == 4'd8);
    assign cbuf_release = out_valid && out_ready && (k == 3'd7);
    assign in_ready     = !fill_full || cbuf_release;
    assign in_fire      = in_valid && in_ready;
    assign frame_ready  = fill_full || (in_fire && fcnt == 4'd7);
    assign load         = frame_ready && (state == ST_IDLE || cbuf_release);
    assign out_last     = out_valid && (k == 3'd7);

    // Next coefficient index to compute: 0 when priming, else k+1 (wraps to 0 at k=7).
    assign row = k + {2'b00, out_valid};

    // Frame as it would look after this edge, including a sample arriving now.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inc[i] = (in_fire && fcnt == 4'(i)) ? in_data : fbuf[i];
        end
    end

    // On a back-to-back handover the new frame's k=0 is computed straight from
    // the incoming frame so no bubble appears on the output.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            dot_x[i] = cbuf_release ? inc[i] : cbuf[i];
            coef[i]  = COEF_TAB[{row, 3'(i)}][CF+1:0];
        end
    end

    dct_dot8 #(
        .BWi   (BWi),
        .CF    (CF),
        .ACC_W (ACC_W)
    ) u_dot8 (
        .x (dot_x),
        .c (coef),
        .y (y)
    );

`ifdef DCT_1D_STREAM_SAT_EN
    always_comb begin
        if (y > Y_MAX)      y_out = Y_MAX[BWo-1:0];
        else if (y < Y_MIN) y_out = Y_MIN[BWo-1:0];
        else                y_out = y[BWo-1:0];
    end
`else
    logic unused_y_hi;
    assign unused_y_hi = ^{y[ACC_W-1:BWo], Y_MAX, Y_MIN};
    always_comb begin
        y_out = y[BWo-1:0];
    end
`endif

    // Fill side: collects x[0..7] in arrival order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
            for (int i = 0; i < N; i++) fbuf[i] <= '0;
        end else if (load) begin
            if (fill_full && in_fire) begin
                fbuf[0] <= in_data;
                fcnt    <= 4'd1;
            end else begin
                fcnt <= 4'd0;
            end
        end else if (in_fire) begin
            fbuf[fcnt[2:0]] <= in_data;
            fcnt            <= fcnt + 4'd1;
        end
    end

    // Output FSM: RUN with out_valid low is the one-cycle prime after a load from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < N; i++) cbuf[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        cbuf  <= inc;
                        state <= ST_RUN;
                        k     <= '0;
                    end
                end
                ST_RUN: begin
                    if (!out_valid) begin
                        out_data  <= y_out;
                        out_valid <= 1'b1;
                        k         <= '0;
                    end else if (out_ready) begin
                        if (k != 3'd7) begin
                            out_data <= y_out;
                            k        <= k + 3'd1;
                        end else if (load) begin
                            cbuf     <= inc;
                            out_data <= y_out;
                            k        <= '0;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                            k         <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_1d_stream.sv
// tb/tb_dct_1d_stream.sv - scoreboard testbench for dct_1d_stream
`timescale 1ns/1ps
module tb_dct_1d_stream;

    typedef struct {
        int y;
        int k;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [9:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              dut8_in_ready;
    logic signed [7:0] dut8_out_data;
    logic              dut8_out_valid;
    logic              dut8_out_last;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   got [8];
    int   cyc = 0;
    int   hs_cyc[$];
    bit   rec_hs = 1'b0;
    bit   watch_in = 1'b0;
    int   in_stall = 0;

    dct_1d_stream #(.BWi(8), .BWo(10), .CF(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    dct_1d_stream #(.BWi(8), .BWo(8), .CF(12)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (dut8_in_ready),
        .out_data  (dut8_out_data),
        .out_valid (dut8_out_valid),
        .out_ready (out_ready),
        .out_last  (dut8_out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference coefficient straight from the cosine definition.
    function automatic int cref(input int k, input int n);
        real s;
        real v;
        s = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
        v = 4096.0 * s * $cos(real'((2 * n + 1) * k) * 3.141592653589793 / 16.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int model_y(input int xs[8], input int k, input int bwo);
        longint acc;
        longint y;
        acc = 0;
        for (int n = 0; n < 8; n++) acc += longint'(xs[n]) * longint'(cref(k, n));
        y = (acc + 2048) >>> 12;
`ifdef DCT_1D_STREAM_SAT_EN
        if (y > (64'sd1 <<< (bwo - 1)) - 1) y = (64'sd1 <<< (bwo - 1)) - 1;
        if (y < -(64'sd1 <<< (bwo - 1)))    y = -(64'sd1 <<< (bwo - 1));
`else
        y = y & ((64'sd1 <<< bwo) - 1);
        if (y >= (64'sd1 <<< (bwo - 1))) y -= (64'sd1 <<< bwo);
`endif
        return int'(y);
    endfunction

    task automatic push_frame(input int xs[8]);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.y = model_y(xs, k, 10);
            e.k = k;
            exp_q.push_back(e);
        end
    endtask

    task automatic put_sample(input int v);
        int w;
        w = 0;
        in_data  = 8'(v);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got in_ready=%b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d out_valid=%b exp 0 0", tag, exp_q.size(), out_valid);
        end
    endtask

    // Scoreboard: a handshake happens at the next posedge when both are high here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (rec_hs) hs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %0d exp none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== 10'(mon_e.y) || out_last !== (mon_e.k == 7)) begin
                    errors++;
                    $display("FAIL coef_k%0d got %0d last=%b exp %0d last=%b",
                             mon_e.k, out_data, out_last, mon_e.y, (mon_e.k == 7));
                end
                got[mon_e.k] = int'(out_data);
            end
        end
        if (watch_in && in_valid && !in_ready) in_stall++;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b/%b exp 0/0", out_valid, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        checks++;
        if (out_data !== 10'sd0) begin
            errors++;
            $display("FAIL reset_out_data got %0d exp 0", out_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_dc_latency();
        int xs[8];
        int bad;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) xs[i] = 100;
        push_frame(xs);
        for (int i = 0; i < 8; i++) put_sample(xs[i]);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got out_valid=%b exp 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'sd283) begin
            errors++;
            $display("FAIL latency_k0 got valid=%b data=%0d exp 1 283", out_valid, out_data);
        end
        wait_drain("dc");
        bad = 0;
        for (int k = 0; k < 8; k++) if (got[k] != ((k == 0) ? 283 : 0)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dc_frame got y0=%0d y1=%0d y7=%0d exp 283 0 0", got[0], got[1], got[7]);
        end
    endtask

    task automatic test_impulse();
        int xs[8];
        for (int i = 0; i < 8; i++) xs[i] = (i == 0) ? 64 : 0;
        push_frame(xs);
        for (int i = 0; i < 8; i++) put_sample(xs[i]);
        wait_drain("impulse");
        checks++;
        if (got[0] != 23 || got[1] != 31) begin
            errors++;
            $display("FAIL impulse got y0=%0d y1=%0d exp 23 31", got[0], got[1]);
        end
    endtask

    task automatic test_wrap();
        int xs[8];
        int exp8;
`ifdef DCT_1D_STREAM_SAT_EN
        exp8 = 127;
`else
        exp8 = 103;
`endif
        for (int i = 0; i < 8; i++) xs[i] = 127;
        push_frame(xs);
        for (int i = 0; i < 8; i++) put_sample(xs[i]);
        @(posedge clk);
        #1;
        checks++;
        if (dut8_out_valid !== 1'b1 || dut8_out_data !== 8'(exp8)) begin
            errors++;
            $display("FAIL bwo8_y0 got valid=%b data=%0d exp 1 %0d", dut8_out_valid, dut8_out_data, exp8);
        end
        wait_drain("wrap");
        checks++;
        if (got[0] != 359) begin
            errors++;
            $display("FAIL bwo10_y0 got %0d exp 359", got[0]);
        end
    endtask

    task automatic test_stall();
        int xa[8];
        int xb[8];
        int w;
        int bad;
        int gaps;
        logic signed [9:0] held;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xa[i] = i * 13 - 40;
            xb[i] = 90 - i * 25;
        end
        push_frame(xa);
        for (int i = 0; i < 8; i++) put_sample(xa[i]);
        w = 0;
        while (!(out_valid && exp_q.size() > 0 && exp_q[0].k == 3) && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        out_ready = 1'b0;
        held = out_data;
        checks++;
        if (!out_valid || exp_q.size() != 5 || held !== 10'(exp_q[0].y)) begin
            errors++;
            $display("FAIL stall_k3 got valid=%b data=%0d pending=%0d exp 1 %0d 5",
                     out_valid, held, exp_q.size(), (exp_q.size() > 0) ? exp_q[0].y : 0);
        end
        push_frame(xb);
        for (int i = 0; i < 8; i++) put_sample(xb[i]);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready got %b exp 0", in_ready);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles exp 0", bad);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        gaps = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (!out_valid) gaps++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (gaps != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_release got gaps=%0d pending=%0d exp 0 0", gaps, exp_q.size());
        end
        wait_drain("stall");
    endtask

    task automatic test_back_to_back();
        int xs[8];
        out_ready = 1'b1;
        hs_cyc.delete();
        in_stall = 0;
        rec_hs   = 1'b1;
        watch_in = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
            push_frame(xs);
            for (int i = 0; i < 8; i++) put_sample(xs[i]);
        end
        watch_in = 1'b0;
        wait_drain("b2b");
        rec_hs = 1'b0;
        checks++;
        if (in_stall != 0) begin
            errors++;
            $display("FAIL b2b_in_ready got %0d low cycles exp 0", in_stall);
        end
        checks++;
        if (hs_cyc.size() != 32 || (hs_cyc[hs_cyc.size() - 1] - hs_cyc[0]) != 31) begin
            errors++;
            $display("FAIL b2b_throughput got n=%0d span=%0d exp 32 31", hs_cyc.size(),
                     (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size() - 1] - hs_cyc[0] : -1);
        end
    endtask

    task automatic test_random();
        int xs[8];
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
                    push_frame(xs);
                    for (int i = 0; i < 8; i++) put_sample(xs[i]);
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("random");
    endtask

    task automatic test_reset_mid();
        int xp[8];
        int xr[8];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xp[i] = 50 - i * 11;
            xr[i] = (i % 2 == 0) ? 120 : -120;
        end
        push_frame(xp);
        for (int i = 0; i < 8; i++) put_sample(xp[i]);
        for (int i = 0; i < 5; i++) put_sample(77);
        checks++;
        if (!out_valid || exp_q.size() == 0 || exp_q[0].k != 4) begin
            errors++;
            $display("FAIL mid_k4 got valid=%b pending=%0d exp 1 4", out_valid, exp_q.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || out_data !== 10'sd0) begin
            errors++;
            $display("FAIL mid_reset got valid=%b last=%b in_ready=%b data=%0d exp 0 0 1 0",
                     out_valid, out_last, in_ready, out_data);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_frame(xr);
        for (int i = 0; i < 8; i++) put_sample(xr[i]);
        wait_drain("mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dc_latency();
        test_impulse();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_1d_stream.md
DCT_1D_STREAM -- requirements
Module: dct_1d_stream

Interface
REQ-001 SHALL have parameter BWi, default 8, meaning the signed input sample width.
REQ-002 SHALL have parameter BWo, default 10, meaning the signed output coefficient width.
REQ-003 SHALL have parameter CF, default 12, meaning the fractional bits of the cosine coefficients.
REQ-004 SHALL have one clock and one asynchronous, active-high reset: clk, rst.
REQ-005 Ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-006 Ports: in_data  in  BWi  signed sample; in_valid  in  1  sample present; in_ready  out  1  sample accepted when high with in_valid.
REQ-007 Ports: out_data  out  BWo  signed coefficient; out_valid  out  1  coefficient present; out_ready  in  1  downstream accepts; out_last  out  1  high with coefficient k=7.

Function
REQ-008 SHALL accept a sample on any rising clk edge with in_valid and in_ready both high; 8 accepted samples form one frame x[0..7] in arrival order.
REQ-009 SHALL hold two frame buffers: a fill buffer (input side) and a compute buffer (output side).
REQ-010 When the 8th sample is accepted and the compute buffer is free, the frame SHALL move to the compute buffer on that same edge.
REQ-011 in_ready SHALL be low only while the fill buffer holds 8 samples and the compute buffer is still busy.
REQ-012 Output FSM states: IDLE (compute buffer empty) and RUN (emitting k=0..7).
REQ-013 Transitions: IDLE->RUN on frame load; RUN->RUN on the k=7 handshake when a full fill buffer loads on that edge; otherwise RUN->IDLE on the k=7 handshake.
REQ-014 Coefficient table: C[k][n] = round(2^CF * s_k * cos((2n+1)k*pi/16)), with s_0 = 1/(2*sqrt(2)) and s_k = 1/2 for k>0, signed CF+2 bits.
REQ-015 y[k] = (sum over n of x[n]*C[k][n] + 2^(CF-1)) >>> CF, arithmetic shift; the accumulator SHALL be full precision (BWi+CF+5 bits).
REQ-016 out_data SHALL be registered; coefficient k is computed from the compute buffer and presented in order k=0..7.
REQ-017 Latency: when the 8th sample is accepted at edge T into a free compute buffer, out_valid with k=0 SHALL be high after edge T+1.
REQ-018 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0; k advances only on a handshake.
REQ-019 Simultaneous events: the k=7 handshake and a pending full fill buffer SHALL load the next frame with no bubble, so k=0 of the new frame follows after one edge.
REQ-020 Sustained throughput SHALL be 8 samples in and 8 coefficients out per 8 cycles when out_ready=1.
REQ-021 out_last SHALL equal out_valid AND (k==7).

Reset
REQ-022 On rst=1 (asynchronous): out_data=0, out_valid=0, out_last=0, in_ready=1, FSM=IDLE, sample count=0, k=0, and both buffers empty.
REQ-023 Reset mid-frame or mid-output SHALL discard all partial and pending frames; the first sample after reset release is x[0] of a new frame.

Configuration
REQ-024 Macro DCT_1D_STREAM_SAT_EN: when defined, y[k] SHALL saturate to [-2^(BWo-1), 2^(BWo-1)-1].
REQ-025 When DCT_1D_STREAM_SAT_EN is undefined, y[k] SHALL be truncated to its low BWo bits (two's-complement wrap).

Structure
REQ-026 Package dct_pkg SHALL hold N=8, the coefficient-table function/constant for C[k][n] given CF, and the FSM state typedef.
REQ-027 Sub-module dct_dot8 SHALL compute the 8-term signed dot product plus rounding of REQ-015 (combinational); dct_1d_stream instantiates it once.

Verification
REQ-028 Defaults, all x[n]=100, out_ready=1 -> y = 283,0,0,0,0,0,0,0; out_last on the 8th output; k=0 valid after edge T+1.
REQ-029 Impulse x[0]=64, others 0 -> y[0]=23, y[1]=31 (64*2009>>>12 rounded); remaining values match the table to within 0 LSB of the reference model.
REQ-030 BWo=8, all x[n]=127 -> with SAT_EN y[0]=127; without SAT_EN y[0]=103 (359 wrapped).
REQ-031 out_ready held 0 for 20 cycles during k=3 of frame A with frame B fully received -> out_data stable at y_A[3], in_ready=0 after B's 8th sample, no sample lost; on release A completes then B follows bubble-free.
REQ-032 Back-to-back 4 frames, in_valid=out_ready=1 -> in_ready constantly 1, 32 outputs in 32 consecutive cycles after first latency.
REQ-033 rst asserted after 5 samples of a frame and during k=4 of the prior frame -> out_valid=0 immediately; the next 8 samples yield one correct frame.
